// File: rtl/mem_axi4_model_pkg.sv
// Shared types, response codes and address mapping for the behavioural AXI4 memory slave.
package mem_axi4_model_pkg;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_WAIT  = 2'd1,
        RD_BURST = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_DATA = 2'd1,
        WR_RESP = 2'd2
    } wr_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Drops the byte offset, then keeps idx_bits of word index so upper address bits alias.
    function automatic logic [63:0] addr_to_index(input logic [63:0] addr,
                                                  input int unsigned offs_bits,
                                                  input int unsigned idx_bits);
        logic [63:0] mask;
        mask = (64'd1 << idx_bits) - 64'd1;
        return (addr >> offs_bits) & mask;
    endfunction

endpackage

// File: rtl/mem_axi4_backing_store.sv
// Word array with a combinational read port and a byte-strobed synchronous write port.
module mem_axi4_backing_store #(
    parameter int unsigned DATA_BITS   = 64,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned IDX_BITS    = $clog2(DEPTH_WORDS)
) (
    input  logic                   i_clk,
    input  logic [IDX_BITS-1:0]    i_rd_idx,
    output logic [DATA_BITS-1:0]   o_rd_data,
    input  logic                   i_we,
    input  logic [IDX_BITS-1:0]    i_wr_idx,
    input  logic [DATA_BITS-1:0]   i_wr_data,
    input  logic [DATA_BITS/8-1:0] i_wr_strb
);

    localparam int unsigned STRB_BITS = DATA_BITS / 8;

    // Contents are deliberately not reset so data survives an engine reset.
    logic [DATA_BITS-1:0] r_mem [DEPTH_WORDS];

    assign o_rd_data = r_mem[i_rd_idx];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < STRB_BITS; b++) begin
                if (i_wr_strb[b]) begin
                    r_mem[i_wr_idx][b*8 +: 8] <= i_wr_data[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/mem_axi4_slave_model.sv
// AXI4 INCR-burst memory slave with independent read and write engines and a fixed read latency.
module mem_axi4_slave_model
    import mem_axi4_model_pkg::*;
#(
    parameter int unsigned ADDR_BITS    = 32,
    parameter int unsigned DATA_BITS    = 64,
    parameter int unsigned ID_BITS      = 4,
    parameter int unsigned DEPTH_WORDS  = 4096,
    parameter int unsigned READ_LATENCY = 4
) (
    input  logic                   clock,
    input  logic                   reset,

    input  logic                   mem_ar_valid,
    input  logic [ADDR_BITS-1:0]   mem_ar_bits_addr,
    input  logic [ID_BITS-1:0]     mem_ar_bits_id,
    input  logic [2:0]             mem_ar_bits_size,
    input  logic [7:0]             mem_ar_bits_len,
    output logic                   mem_ar_ready,

    input  logic                   mem_aw_valid,
    input  logic [ADDR_BITS-1:0]   mem_aw_bits_addr,
    input  logic [ID_BITS-1:0]     mem_aw_bits_id,
    input  logic [2:0]             mem_aw_bits_size,
    input  logic [7:0]             mem_aw_bits_len,
    output logic                   mem_aw_ready,

    input  logic                   mem_w_valid,
    input  logic [DATA_BITS-1:0]   mem_w_bits_data,
    input  logic [DATA_BITS/8-1:0] mem_w_bits_strb,
    input  logic                   mem_w_bits_last,
    output logic                   mem_w_ready,

    output logic                   mem_r_valid,
    output logic [DATA_BITS-1:0]   mem_r_bits_data,
    output logic [ID_BITS-1:0]     mem_r_bits_id,
    output logic [1:0]             mem_r_bits_resp,
    output logic                   mem_r_bits_last,
    input  logic                   mem_r_ready,

    output logic                   mem_b_valid,
    output logic [ID_BITS-1:0]     mem_b_bits_id,
    output logic [1:0]             mem_b_bits_resp,
    input  logic                   mem_b_ready
);

    localparam int unsigned STRB_BITS = DATA_BITS / 8;
    localparam int unsigned OFFS_BITS = $clog2(STRB_BITS);
    localparam int unsigned IDX_BITS  = $clog2(DEPTH_WORDS);
    localparam logic [2:0]  FULL_SIZE = 3'(OFFS_BITS);
    localparam logic [7:0]  LAT_LOAD  = 8'(READ_LATENCY - 1);

    rd_state_e             r_rd_state, w_rd_state_d;
    logic [ID_BITS-1:0]    r_rd_id;
    logic [IDX_BITS-1:0]   r_rd_idx;
    logic [7:0]            r_rd_len, r_rd_beat, r_rd_cnt;
    logic                  r_rd_err;

    wr_state_e             r_wr_state, w_wr_state_d;
    logic [ID_BITS-1:0]    r_wr_id;
    logic [IDX_BITS-1:0]   r_wr_idx;
    logic [7:0]            r_wr_len, r_wr_beat;
    logic                  r_wr_err;

    logic                  w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs;
    logic                  w_rd_at_end, w_wr_at_end, w_w_last_bad, w_we;
    logic [IDX_BITS-1:0]   w_ar_idx, w_aw_idx;
    logic [DATA_BITS-1:0]  w_rd_data;

    assign w_ar_idx = IDX_BITS'(addr_to_index(64'(mem_ar_bits_addr), OFFS_BITS, IDX_BITS));
    assign w_aw_idx = IDX_BITS'(addr_to_index(64'(mem_aw_bits_addr), OFFS_BITS, IDX_BITS));

    // Readies are gated with reset so they read 0 while reset is held.
    assign mem_ar_ready = reset && (r_rd_state == RD_IDLE);
    assign mem_aw_ready = reset && (r_wr_state == WR_IDLE);
    assign mem_w_ready  = (r_wr_state == WR_DATA);
    assign mem_r_valid  = (r_rd_state == RD_BURST);
    assign mem_b_valid  = (r_wr_state == WR_RESP);

    assign w_ar_hs = mem_ar_valid && mem_ar_ready;
    assign w_r_hs  = mem_r_valid && mem_r_ready;
    assign w_aw_hs = mem_aw_valid && mem_aw_ready;
    assign w_w_hs  = mem_w_valid && mem_w_ready;
    assign w_b_hs  = mem_b_valid && mem_b_ready;

    assign w_rd_at_end  = (r_rd_beat == r_rd_len);
    assign w_wr_at_end  = (r_wr_beat == r_wr_len);
    assign w_w_last_bad = (mem_w_bits_last != w_wr_at_end);
    // The beat that exposes a w_last mismatch is itself never committed.
    assign w_we         = w_w_hs && !r_wr_err && !w_w_last_bad;

    assign mem_r_bits_data = (mem_r_valid && !r_rd_err) ? w_rd_data : '0;
    assign mem_r_bits_id   = r_rd_id;
    assign mem_r_bits_resp = (mem_r_valid && r_rd_err) ? RESP_SLVERR : RESP_OKAY;
    assign mem_r_bits_last = mem_r_valid && w_rd_at_end;
    assign mem_b_bits_id   = r_wr_id;
    assign mem_b_bits_resp = (mem_b_valid && r_wr_err) ? RESP_SLVERR : RESP_OKAY;

    mem_axi4_backing_store #(
        .DATA_BITS   (DATA_BITS),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_BITS    (IDX_BITS)
    ) u_store (
        .i_clk     (clock),
        .i_rd_idx  (r_rd_idx),
        .o_rd_data (w_rd_data),
        .i_we      (w_we),
        .i_wr_idx  (r_wr_idx),
        .i_wr_data (mem_w_bits_data),
        .i_wr_strb (mem_w_bits_strb)
    );

    always_comb begin
        w_rd_state_d = r_rd_state;
        unique case (r_rd_state)
            RD_IDLE:  if (w_ar_hs) w_rd_state_d = (READ_LATENCY == 1) ? RD_BURST : RD_WAIT;
            RD_WAIT:  if (r_rd_cnt == 8'd1) w_rd_state_d = RD_BURST;
            RD_BURST: if (w_r_hs && w_rd_at_end) w_rd_state_d = RD_IDLE;
            default:  w_rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_state <= RD_IDLE;
            r_rd_id    <= '0;
            r_rd_idx   <= '0;
            r_rd_len   <= '0;
            r_rd_beat  <= '0;
            r_rd_cnt   <= '0;
            r_rd_err   <= 1'b0;
        end else begin
            r_rd_state <= w_rd_state_d;
            if (r_rd_state == RD_IDLE && w_ar_hs) begin
                r_rd_id   <= mem_ar_bits_id;
                r_rd_idx  <= w_ar_idx;
                r_rd_len  <= mem_ar_bits_len;
                r_rd_beat <= '0;
                r_rd_cnt  <= LAT_LOAD;
                r_rd_err  <= (mem_ar_bits_size != FULL_SIZE);
            end else if (r_rd_state == RD_WAIT) begin
                r_rd_cnt <= r_rd_cnt - 8'd1;
            end else if (w_r_hs) begin
                r_rd_idx  <= r_rd_idx + IDX_BITS'(1);
                r_rd_beat <= r_rd_beat + 8'd1;
            end
        end
    end

    always_comb begin
        w_wr_state_d = r_wr_state;
        unique case (r_wr_state)
            WR_IDLE: if (w_aw_hs) w_wr_state_d = WR_DATA;
            WR_DATA: if (w_w_hs && (mem_w_bits_last || w_wr_at_end)) w_wr_state_d = WR_RESP;
            WR_RESP: if (w_b_hs) w_wr_state_d = WR_IDLE;
            default: w_wr_state_d = WR_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_state <= WR_IDLE;
            r_wr_id    <= '0;
            r_wr_idx   <= '0;
            r_wr_len   <= '0;
            r_wr_beat  <= '0;
            r_wr_err   <= 1'b0;
        end else begin
            r_wr_state <= w_wr_state_d;
            if (r_wr_state == WR_IDLE && w_aw_hs) begin
                r_wr_id   <= mem_aw_bits_id;
                r_wr_idx  <= w_aw_idx;
                r_wr_len  <= mem_aw_bits_len;
                r_wr_beat <= '0;
                r_wr_err  <= (mem_aw_bits_size != FULL_SIZE);
            end else if (w_w_hs) begin
                r_wr_idx  <= r_wr_idx + IDX_BITS'(1);
                r_wr_beat <= r_wr_beat + 8'd1;
                if (w_w_last_bad) r_wr_err <= 1'b1;
            end
        end
    end

endmodule
